// File: rtl/gray_ticket_arbiter.sv
// gray_ticket_arbiter: round-robin arbiter handing out Gray-coded tickets from one shared counter.
// Define GRAY_TICKET_SATURATE_EN to stop at the last code and raise the exhausted port.
module gray_ticket_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [WIDTH-1:0] ticket_gray,
    output logic             ticket_valid,
    output logic             wrap,
    output logic             busy
`ifdef GRAY_TICKET_SATURATE_EN
    ,
    output logic             exhausted
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef GRAY_TICKET_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GRANT, DROP} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_q, rr_d, win_q, win_d, pick, idx;
    logic [WIDTH-1:0] bin_q, bin_d, tg_q, tg_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             tv_q, tv_d, wrap_q, wrap_d, exh_q, exh_d;
    logic             found, grant, last;

    // Rotating priority scan starting at rr_q
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        idx   = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(rr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            IDLE: if (|req && !exh_q) begin
                state_d = GRANT;
                win_d   = pick;
            end
            GRANT:   state_d = DROP;
            DROP:    state_d = req[win_q] ? DROP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ticket outputs are registered, so they appear the cycle after GRANT
    always_comb begin
        grant  = state_q == GRANT;
        last   = &bin_q;
        ack_d  = grant ? NREQ'(1) << win_q : '0;
        tv_d   = grant;
        wrap_d = grant && last;
        tg_d   = grant ? bin_q ^ (bin_q >> 1) : tg_q;
        rr_d   = grant ? ((win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1) : rr_q;
        bin_d  = clr ? '0 : (grant && !(SAT && last)) ? bin_q + 1'b1 : bin_q;
        exh_d  = clr ? 1'b0 : (exh_q || (SAT && grant && last));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= '0;
            bin_q  <= '0;
            tg_q   <= '0;
            ack_q  <= '0;
            tv_q   <= 1'b0;
            wrap_q <= 1'b0;
            exh_q  <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            bin_q  <= bin_d;
            tg_q   <= tg_d;
            ack_q  <= ack_d;
            tv_q   <= tv_d;
            wrap_q <= wrap_d;
            exh_q  <= exh_d;
        end
    end

    assign ack          = ack_q;
    assign ticket_gray  = tg_q;
    assign ticket_valid = tv_q;
    assign wrap         = wrap_q;
    assign busy         = state_q != IDLE;
`ifdef GRAY_TICKET_SATURATE_EN
    assign exhausted    = exh_q;
`endif
endmodule

// File: tb/tb_gray_ticket_arbiter.sv
// tb_gray_ticket_arbiter: directed + randomized checks of gray_ticket_arbiter against a ticket/pointer model.
module tb_gray_ticket_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n, clr;
    logic [N-1:0] req, ack;
    logic [3:0]   ticket_gray;
    logic         ticket_valid, wrap, busy;
`ifdef GRAY_TICKET_SATURATE_EN
    logic         exhausted;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int m_cnt, m_rr;

    always #5 clk = ~clk;

    gray_ticket_arbiter #(.NREQ(N), .WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .ack(ack),
        .ticket_gray(ticket_gray), .ticket_valid(ticket_valid), .wrap(wrap), .busy(busy)
`ifdef GRAY_TICKET_SATURATE_EN
        , .exhausted(exhausted)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [3:0] gray(input int n);
        return 4'(n ^ (n >> 1));
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int i = 0; i < N; i++)
            if (r[2'((rr + i) % N)]) return (rr + i) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_rr  = 0;
        @(negedge clk);
    endtask

    // Waits for the next ack, checks it against the model, then drops the winner's req unless held.
    task automatic serve(input int exp_lat, input bit do_clr, input bit hold, output int w);
        int lat;
        int ew;
        ew = pick(req, m_rr);
        w  = -1;
        for (lat = 1; lat <= 8; lat++) begin
            @(negedge clk);
            clr = do_clr && (lat == exp_lat - 1);
            if (|ack) break;
        end
        clr = 1'b0;
        check("ack_seen", |ack, 1);
        if (|ack) begin
            check("latency", lat, exp_lat);
            check("ack_onehot", ack, 1 << ew);
            check("ticket", ticket_gray, gray(m_cnt));
            check("valid", ticket_valid, 1);
            check("wrap", wrap, m_cnt == 15);
            check("busy_at_ack", busy, 1);
            w     = ew;
            m_rr  = (ew + 1) % N;
            m_cnt = do_clr ? 0 : (m_cnt + 1) % 16;
            if (!hold) req[ew] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        req   = '0;
        clr   = 1'b0;
        m_cnt = 0;
        m_rr  = 0;
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_ticket", ticket_gray, 0);
        check("rst_valid", ticket_valid, 0);
        check("rst_wrap", wrap, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        req = 4'b0001;
        serve(2, 1'b0, 1'b0, w);
        check("first_ticket", ticket_gray, 4'b0000);
        @(negedge clk);
        check("ack_pulse", ack, 0);
        check("valid_pulse", ticket_valid, 0);
        check("busy_after_drop", busy, 0);

        do_reset();
        req = 4'b1111;
        serve(2, 1'b0, 1'b0, w);
        check("order_0", w, 0);
        for (int k = 1; k < 4; k++) begin
            serve(3, 1'b0, 1'b0, w);
            check("order_k", w, k);
        end
        check("fourth_ticket", ticket_gray, 4'b0010);

        for (int k = 4; k < 16; k++) begin
            @(negedge clk);
            req = req | 4'($urandom_range(1, 15));
            serve(2, 1'b0, 1'b0, w);
        end
        check("wrap_ticket", ticket_gray, 4'b1000);
        check("wrap_flag", wrap, 1);
        @(negedge clk);
`ifdef GRAY_TICKET_SATURATE_EN
        check("exhausted_set", exhausted, 1);
        req = req | 4'b0001;
        repeat (5) begin
            @(negedge clk);
            check("sat_no_ack", ack, 0);
        end
        check("sat_idle", busy, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("exhausted_clr", exhausted, 0);
        serve(2, 1'b0, 1'b0, w);
        check("ticket_after_clr", ticket_gray, 4'b0000);
`else
        req = req | 4'b0001;
        serve(2, 1'b0, 1'b0, w);
        check("ticket_17", ticket_gray, 4'b0000);
        check("wrap_17", wrap, 0);
`endif

        do_reset();
        for (int k = 0; k < 5; k++) begin
            req = req | 4'($urandom_range(1, 15));
            serve(2, 1'b0, 1'b0, w);
            @(negedge clk);
        end
        req = req | 4'($urandom_range(1, 15));
        serve(2, 1'b1, 1'b0, w);
        check("clr_ticket", ticket_gray, 4'b0111);
        @(negedge clk);
        req = req | 4'($urandom_range(1, 15));
        serve(2, 1'b0, 1'b0, w);
        check("post_clr_ticket", ticket_gray, 4'b0000);
        @(negedge clk);
        req = req | 4'($urandom_range(1, 15));
        serve(2, 1'b0, 1'b0, w);

        rst_n = 1'b0;
        #1;
        check("arst_ack", ack, 0);
        check("arst_valid", ticket_valid, 0);
        check("arst_ticket", ticket_gray, 0);
        check("arst_busy", busy, 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_cnt = 0;
        m_rr  = 0;
        req   = 4'b0010;
        serve(2, 1'b0, 1'b0, w);
        check("arst_first_ticket", ticket_gray, 4'b0000);
        check("arst_first_winner", w, 1);

        do_reset();
        req = 4'b0100;
        serve(2, 1'b0, 1'b1, w);
        req[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("hold_no_ack", ack, 0);
        end
        check("hold_busy", busy, 1);
        req[2] = 1'b0;
        serve(3, 1'b0, 1'b0, w);
        check("hold_next_winner", w, 0);

        do_reset();
        for (int k = 0; k < 12; k++) begin
            req = req | 4'($urandom_range(1, 15));
            serve(2, ($urandom_range(0, 3) == 0), 1'b0, w);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
